// File: rtl/dcache_miss_queue.sv
// In-order miss-request FIFO feeding the dcache refill machine.
// The head entry is shown ahead from registered storage; overflow/underflow flags are sticky.
module dcache_miss_queue #(
   parameter int unsigned DATABITS = 32,
   parameter int unsigned ADDRBITS = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned LVLBITS  = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDRBITS-1:0] in_addr,
   input  logic [DATABITS-1:0] in_data,
   input  logic                in_rdreq,
   input  logic                in_wrreq,
   input  logic [1:0]          in_wordlen,
   input  logic                push,
   input  logic                pop,
   input  logic                clear,
   output logic [ADDRBITS-1:0] out_addr,
   output logic [DATABITS-1:0] out_data,
   output logic                out_rdreq,
   output logic                out_wrreq,
   output logic [1:0]          out_wordlen,
   output logic                not_empty,
   output logic                full,
   output logic [LVLBITS-1:0]  level,
   output logic                overflow,
   output logic                underflow
);

   localparam int unsigned PTRBITS = $clog2(DEPTH);

   logic [ADDRBITS-1:0] addr_mem    [DEPTH];
   logic [DATABITS-1:0] data_mem    [DEPTH];
   logic                rdreq_mem   [DEPTH];
   logic                wrreq_mem   [DEPTH];
   logic [1:0]          wordlen_mem [DEPTH];

   logic [PTRBITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTRBITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVLBITS-1:0] level_q, level_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic               req_valid, pop_ok, push_ok;

   assign not_empty = (level_q != '0);
   assign full      = (level_q == LVLBITS'(DEPTH));
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // A request with neither rd nor wr set is not a request at all.
   assign req_valid = push & (in_rdreq | in_wrreq);
   assign pop_ok    = pop & not_empty;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign push_ok   = req_valid & (~full | pop_ok);

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clear) begin
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (pop_ok) rd_ptr_d = rd_ptr_q + PTRBITS'(1);
         if (push_ok) wr_ptr_d = wr_ptr_q + PTRBITS'(1);
         level_d = level_q + LVLBITS'(push_ok) - LVLBITS'(pop_ok);
         if (pop && !not_empty) underflow_d = 1'b1;
         if (req_valid && full && !pop_ok) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage needs no reset: the output mux hides it while the queue is empty.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         addr_mem[wr_ptr_q]    <= in_addr;
         data_mem[wr_ptr_q]    <= in_data;
         rdreq_mem[wr_ptr_q]   <= in_rdreq & ~in_wrreq;
         wrreq_mem[wr_ptr_q]   <= in_wrreq;
         wordlen_mem[wr_ptr_q] <= in_wordlen;
      end
   end

   always_comb begin
      out_addr    = '0;
      out_data    = '0;
      out_rdreq   = 1'b0;
      out_wrreq   = 1'b0;
      out_wordlen = '0;
      if (not_empty) begin
         out_addr    = addr_mem[rd_ptr_q];
         out_data    = data_mem[rd_ptr_q];
         out_rdreq   = rdreq_mem[rd_ptr_q];
         out_wrreq   = wrreq_mem[rd_ptr_q];
         out_wordlen = wordlen_mem[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_dcache_miss_queue.sv
// Bench for dcache_miss_queue: directed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_dcache_miss_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] in_addr, in_data;
   logic        in_rdreq, in_wrreq;
   logic [1:0]  in_wordlen;
   logic        push, pop, clear;
   logic [31:0] out_addr, out_data;
   logic        out_rdreq, out_wrreq;
   logic [1:0]  out_wordlen;
   logic        not_empty, full, overflow, underflow;
   logic [2:0]  level;

   dcache_miss_queue #(
      .DATABITS(32), .ADDRBITS(32), .DEPTH(DEPTH), .LVLBITS(3)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_addr(in_addr), .in_data(in_data), .in_rdreq(in_rdreq), .in_wrreq(in_wrreq),
      .in_wordlen(in_wordlen), .push(push), .pop(pop), .clear(clear),
      .out_addr(out_addr), .out_data(out_data), .out_rdreq(out_rdreq), .out_wrreq(out_wrreq),
      .out_wordlen(out_wordlen), .not_empty(not_empty), .full(full), .level(level),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rd;
      logic        wr;
      logic [1:0]  wl;
   } ent_t;

   ent_t model_q[$];
   logic m_ov, m_un;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      ent_t h;
      h = '{addr: 0, data: 0, rd: 0, wr: 0, wl: 0};
      if (model_q.size() > 0) h = model_q[0];
      chk("level", 64'(level), 64'(model_q.size()));
      chk("not_empty", 64'(not_empty), 64'(model_q.size() > 0));
      chk("full", 64'(full), 64'(model_q.size() == DEPTH));
      chk("overflow", 64'(overflow), 64'(m_ov));
      chk("underflow", 64'(underflow), 64'(m_un));
      chk("out_addr", 64'(out_addr), 64'(h.addr));
      chk("out_data", 64'(out_data), 64'(h.data));
      chk("out_rdreq", 64'(out_rdreq), 64'(h.rd));
      chk("out_wrreq", 64'(out_wrreq), 64'(h.wr));
      chk("out_wordlen", 64'(out_wordlen), 64'(h.wl));
   endtask

   // Drive one cycle, clock it, advance the model, leave outputs settled for checking.
   task automatic cycle(input logic p, input logic q, input logic c, input logic rd,
                        input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] wl);
      ent_t e;
      push = p; pop = q; clear = c; in_rdreq = rd; in_wrreq = wr;
      in_addr = a; in_data = d; in_wordlen = wl;
      @(posedge clk);
      if (c) begin
         model_q.delete();
         m_ov = 0;
         m_un = 0;
      end else begin
         bit popped;
         popped = 0;
         if (q) begin
            if (model_q.size() > 0) begin
               void'(model_q.pop_front());
               popped = 1;
            end else m_un = 1;
         end
         if (p && (rd || wr)) begin
            // Free slot exists if not full before the edge, or a pop happened with it.
            if (model_q.size() < DEPTH) begin
               e = '{addr: a, data: d, rd: rd && !wr, wr: wr, wl: wl};
               model_q.push_back(e);
            end else if (!popped) m_ov = 1;
         end
      end
      #1;
   endtask

   typedef struct {
      logic        p, q, c, rd, wr;
      logic [31:0] a, d;
      int          lvl;
      logic        ne, fu, ov, un;
      logic [31:0] ha, hd;
   } vec_t;

   vec_t tbl[14];

   initial begin
      reset_n = 0; push = 0; pop = 0; clear = 0; in_rdreq = 0; in_wrreq = 0;
      in_addr = 0; in_data = 0; in_wordlen = 0;
      m_ov = 0; m_un = 0;
      #12 reset_n = 1;
      check_model();
      chk("reset_level", 64'(level), 64'd0);

      //            p q c rd wr addr       data      lvl ne fu ov un head_a    head_d
      tbl[0]  = '{1,0,0,1,0, 32'h100, 32'h0,  1, 1,0,0,0, 32'h100, 32'h0};
      tbl[1]  = '{0,1,0,0,0, 32'h0,   32'h0,  0, 0,0,0,0, 32'h0,   32'h0};
      tbl[2]  = '{1,0,0,0,1, 32'h10,  32'h11, 1, 1,0,0,0, 32'h10,  32'h11};
      tbl[3]  = '{1,0,0,0,1, 32'h20,  32'h22, 2, 1,0,0,0, 32'h10,  32'h11};
      tbl[4]  = '{1,0,0,0,1, 32'h30,  32'h33, 3, 1,0,0,0, 32'h10,  32'h11};
      tbl[5]  = '{1,0,0,0,1, 32'h40,  32'h44, 4, 1,1,0,0, 32'h10,  32'h11};
      tbl[6]  = '{1,0,0,0,1, 32'h50,  32'h55, 4, 1,1,1,0, 32'h10,  32'h11};
      tbl[7]  = '{0,1,0,0,0, 32'h0,   32'h0,  3, 1,0,1,0, 32'h20,  32'h22};
      tbl[8]  = '{0,1,0,0,0, 32'h0,   32'h0,  2, 1,0,1,0, 32'h30,  32'h33};
      tbl[9]  = '{0,1,0,0,0, 32'h0,   32'h0,  1, 1,0,1,0, 32'h40,  32'h44};
      tbl[10] = '{0,1,0,0,0, 32'h0,   32'h0,  0, 0,0,1,0, 32'h0,   32'h0};
      tbl[11] = '{0,1,0,0,0, 32'h0,   32'h0,  0, 0,0,1,1, 32'h0,   32'h0};
      tbl[12] = '{1,0,0,0,0, 32'h60,  32'h66, 0, 0,0,1,1, 32'h0,   32'h0};
      tbl[13] = '{0,0,1,0,0, 32'h0,   32'h0,  0, 0,0,0,0, 32'h0,   32'h0};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 2'b10);
         chk($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].lvl));
         chk($sformatf("vec%0d_not_empty", i), 64'(not_empty), 64'(tbl[i].ne));
         chk($sformatf("vec%0d_full", i), 64'(full), 64'(tbl[i].fu));
         chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(tbl[i].ov));
         chk($sformatf("vec%0d_underflow", i), 64'(underflow), 64'(tbl[i].un));
         chk($sformatf("vec%0d_out_addr", i), 64'(out_addr), 64'(tbl[i].ha));
         chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tbl[i].hd));
         if (i == 0) chk("vec0_out_rdreq", 64'(out_rdreq), 64'd1);
         check_model();
      end

      // Full queue with push+pop together: wraps pointers, no overflow.
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 32'h1000 + i, 32'h100 + i, 2'b10);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 1, 0, 0, 1, 32'h1004 + i, 32'h104 + i, 2'b10);
         chk("fullpp_level", 64'(level), 64'd4);
         chk("fullpp_overflow", 64'(overflow), 64'd0);
         chk("fullpp_head", 64'(out_data), 64'(32'h101 + i));
         check_model();
      end
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 64'(out_data), 64'(32'h106 + i));
         cycle(0, 1, 0, 0, 0, 0, 0, 0);
         check_model();
      end

      // Both rd and wr set is stored as a write; push+pop on empty sets underflow.
      cycle(1, 1, 0, 1, 1, 32'h300, 32'h33, 2'b01);
      chk("rdwr_out_wrreq", 64'(out_wrreq), 64'd1);
      chk("rdwr_out_rdreq", 64'(out_rdreq), 64'd0);
      chk("empty_pp_underflow", 64'(underflow), 64'd1);
      check_model();
      cycle(0, 0, 1, 0, 0, 0, 0, 0);
      check_model();

      // Asynchronous reset mid-cycle with 3 entries stored.
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 32'h400 + i, 0, 2'b00);
      push = 0; pop = 0;
      #2 reset_n = 0;
      #1;
      chk("async_rst_level", 64'(level), 64'd0);
      chk("async_rst_not_empty", 64'(not_empty), 64'd0);
      chk("async_rst_out_addr", 64'(out_addr), 64'd0);
      model_q.delete();
      m_ov = 0;
      m_un = 0;
      #3 reset_n = 1;
      cycle(1, 0, 0, 1, 0, 32'h200, 32'h0, 2'b10);
      chk("post_rst_head", 64'(out_addr), 64'h200);
      check_model();

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic p, q, c, rd, wr;
         p  = ($urandom_range(0, 99) < 60);
         q  = ($urandom_range(0, 99) < 45);
         c  = ($urandom_range(0, 99) < 3);
         rd = 1'($urandom);
         wr = 1'($urandom);
         cycle(p, q, c, rd, wr, $urandom, $urandom, 2'($urandom_range(0, 2)));
         check_model();
      end

      push = 0; pop = 0; clear = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
